// File: rtl/tt_sweep_capture_pkg.sv
// rtl/tt_sweep_capture_pkg.sv - shared types and helpers for the truth-table sweep
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_DONE
  } state_t;

  function automatic int num_patterns(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_sweep_capture_if.sv
// rtl/tt_sweep_capture_if.sv - stimulus/response bundle between sweep sequencer and its user
interface tt_sweep_capture_if #(
  parameter int NUM_INPUTS = 3
);

  logic                       start;
  logic                       f_in;
  logic [NUM_INPUTS-1:0]      stim;
  logic                       busy;
  logic                       done;
  logic [2**NUM_INPUTS-1:0]   tt;
  logic                       tt_valid;

  modport master (
    output start,
    output f_in,
    input  stim,
    input  busy,
    input  done,
    input  tt,
    input  tt_valid
  );

  modport slave (
    input  start,
    input  f_in,
    output stim,
    output busy,
    output done,
    output tt,
    output tt_valid
  );

endinterface

// File: rtl/tt_sweep_capture_hold_timer.sv
// rtl/tt_sweep_capture_hold_timer.sv - counts hold cycles per pattern, flags the sampling edge
module tt_hold_timer #(
  parameter int HOLD_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam int W = $clog2(HOLD_CYCLES + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign last = (count == W'(HOLD_CYCLES - 1));

endmodule

// File: rtl/tt_sweep_capture.sv
// rtl/tt_sweep_capture.sv - sweeps all input patterns of a small combinational unit
// and captures its response into a registered truth-table word.
module tt_sweep_capture
  import tt_sweep_pkg::*;
#(
  parameter int NUM_INPUTS  = 3,
  parameter int HOLD_CYCLES = 10
) (
  input logic             clk,
  input logic             rst,
  tt_sweep_capture_if.slave bus
);

  localparam int                    PATTERNS = num_patterns(NUM_INPUTS);
  localparam logic [NUM_INPUTS-1:0] LAST_IDX = NUM_INPUTS'(PATTERNS - 1);

  state_t                state, state_next;
  logic [NUM_INPUTS-1:0] idx, idx_next;
  logic [PATTERNS-1:0]   tt_q, tt_next;
  logic                  tt_valid_q, tt_valid_next;
  logic [NUM_INPUTS-1:0] stim_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  timer_clear;
  logic                  timer_enable;
  logic                  timer_last;

  tt_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .enable(timer_enable),
    .last  (timer_last)
  );

  always_comb begin
    state_next    = state;
    idx_next      = idx;
    tt_next       = tt_q;
    tt_valid_next = tt_valid_q;
    timer_clear   = 1'b0;
    timer_enable  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_next    = ST_HOLD;
          idx_next      = '0;
          tt_valid_next = 1'b0;
          timer_clear   = 1'b1;
        end
      end
      ST_HOLD: begin
        timer_enable = 1'b1;
        if (timer_last) begin
          tt_next[idx] = bus.f_in;
          if (idx == LAST_IDX) begin
            state_next = ST_DONE;
          end else begin
            idx_next    = idx + 1'b1;
            timer_clear = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_next    = ST_IDLE;
        tt_valid_next = 1'b1;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outputs are registered from next-state values so stim moves on the sampling edge itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      tt_q       <= '0;
      tt_valid_q <= 1'b0;
      stim_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      idx        <= idx_next;
      tt_q       <= tt_next;
      tt_valid_q <= tt_valid_next;
      stim_q     <= (state_next == ST_IDLE) ? '0 : idx_next;
      busy_q     <= (state_next != ST_IDLE);
      done_q     <= (state_next == ST_DONE);
    end
  end

  assign bus.stim     = stim_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.tt       = tt_q;
  assign bus.tt_valid = tt_valid_q;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// tb/tb_tt_sweep_capture.sv - three sweep instances (N3/H10, N3/H1, N2/H3) against a timing model
module tb_tt_sweep_capture;

  localparam int PAT [3] = '{8, 8, 4};
  localparam int HLD [3] = '{10, 1, 3};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]      start;
  logic [2:0][2:0] sel;
  logic [2:0][7:0] o_stim;
  logic [2:0][7:0] o_tt;
  logic [2:0]      o_busy;
  logic [2:0]      o_done;
  logic [2:0]      o_valid;

  // unit functions: 0 a^b^c, 1 a&b&c, 2 ~c, 3 a|b, 4 stim[1]
  function automatic logic fn(input logic [2:0] s, input logic [7:0] v);
    case (s)
      3'd0:    return ^v[2:0];
      3'd1:    return &v[2:0];
      3'd2:    return ~v[0];
      3'd3:    return v[2] | v[1];
      3'd4:    return v[1];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] table_of(input logic [2:0] s, input int p);
    logic [7:0] t;
    t = '0;
    for (int i = 0; i < p; i++) t[i] = fn(s, 8'(i));
    return t;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int N = (g == 2) ? 2 : 3;
    localparam int H = (g == 0) ? 10 : ((g == 1) ? 1 : 3);
    tt_sweep_capture_if #(.NUM_INPUTS(N)) bus ();
    tt_sweep_capture #(.NUM_INPUTS(N), .HOLD_CYCLES(H)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
    assign bus.start  = start[g];
    assign bus.f_in   = fn(sel[g], o_stim[g]);
    assign o_stim[g]  = 8'(bus.stim);
    assign o_tt[g]    = 8'(bus.tt);
    assign o_busy[g]  = bus.busy;
    assign o_done[g]  = bus.done;
    assign o_valid[g] = bus.tt_valid;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // model: sweep accepted at edge k=0; pattern k/H while k<P*H; done at k=P*H; idle next edge
  logic [2:0]      m_act;
  int              m_k [3];
  logic [2:0]      m_valid;
  logic [2:0][7:0] m_tab;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int g = 0; g < 3; g++) begin
        m_act[g]   <= 1'b0;
        m_k[g]     <= 0;
        m_valid[g] <= 1'b0;
        m_tab[g]   <= '0;
      end
    end else begin
      for (int g = 0; g < 3; g++) begin
        if (m_act[g]) begin
          if (m_k[g] == PAT[g] * HLD[g]) begin
            m_act[g]   <= 1'b0;
            m_valid[g] <= 1'b1;
          end else begin
            m_k[g] <= m_k[g] + 1;
          end
        end else if (start[g]) begin
          m_act[g]   <= 1'b1;
          m_k[g]     <= 0;
          m_valid[g] <= 1'b0;
          m_tab[g]   <= table_of(sel[g], PAT[g]);
        end
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d cyc=%0d actual=%0h expected=%0h", name, g, cyc, act, exp);
    end
  endtask

  // literal expectations armed by the stimulus
  logic [2:0][7:0] lit_tt;
  int lit_done_cyc [3];
  int lit_period   [3];
  int lit_base     [3];
  int exp_ndone    [3];
  int req_seq      [3];
  int ndone        [3];
  int seen_seq     [3];

  logic       e_done;
  logic [7:0] e_stim;

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rst) begin
        chk("rst_stim", g, 32'(o_stim[g]), 32'd0);
        chk("rst_busy", g, 32'(o_busy[g]), 32'd0);
        chk("rst_done", g, 32'(o_done[g]), 32'd0);
        chk("rst_tt", g, 32'(o_tt[g]), 32'd0);
        chk("rst_tt_valid", g, 32'(o_valid[g]), 32'd0);
      end else begin
        e_done = m_act[g] && (m_k[g] == PAT[g] * HLD[g]);
        e_stim = !m_act[g] ? 8'd0 : (e_done ? 8'(PAT[g] - 1) : 8'(m_k[g] / HLD[g]));
        chk("stim", g, 32'(o_stim[g]), 32'(e_stim));
        chk("busy", g, 32'(o_busy[g]), 32'(m_act[g]));
        chk("done", g, 32'(o_done[g]), 32'(e_done));
        chk("tt_valid", g, 32'(o_valid[g]), 32'(m_valid[g]));
        if (e_done || m_valid[g]) chk("tt", g, 32'(o_tt[g]), 32'(m_tab[g]));
        if (o_done[g]) begin
          chk("lit_tt", g, 32'(o_tt[g]), 32'(lit_tt[g]));
          chk("lit_done_cyc", g, 32'(cyc),
              32'(lit_done_cyc[g] + lit_period[g] * (ndone[g] - lit_base[g])));
          ndone[g] = ndone[g] + 1;
        end
      end
      if (req_seq[g] != seen_seq[g]) begin
        chk("done_count", g, 32'(ndone[g]), 32'(exp_ndone[g]));
        seen_seq[g] = req_seq[g];
      end
    end
  end

  int base_done [3];

  task automatic arm(input int g, input int off, input int period, input logic [7:0] tab);
    lit_tt[g]       = tab;
    lit_done_cyc[g] = cyc + off;
    lit_period[g]   = period;
    lit_base[g]     = ndone[g];
    base_done[g]    = ndone[g];
  endtask

  task automatic expect_dones(input int g, input int n);
    exp_ndone[g] = base_done[g] + n;
    req_seq[g]   = req_seq[g] + 1;
  endtask

  task automatic pulse_start(input int g);
    start[g] = 1'b1;
    @(posedge clk);
    #1 start[g] = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = '0;
    sel[0] = 3'd0;
    sel[1] = 3'd3;
    sel[2] = 3'd4;
    lit_tt = '0;
    for (int g = 0; g < 3; g++) begin
      lit_done_cyc[g] = 0; lit_period[g] = 0; lit_base[g] = 0;
      exp_ndone[g] = 0; req_seq[g] = 0; ndone[g] = 0; seen_seq[g] = 0; base_done[g] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // parity, single start pulse
    @(posedge clk);
    #1 arm(0, 81, 0, 8'h96);
    pulse_start(0);
    repeat (85) @(posedge clk);
    #1 expect_dones(0, 1);

    // AND, with extra ignored starts at cycles 5 and 40 of the sweep
    sel[0] = 3'd1;
    @(posedge clk);
    #1 arm(0, 81, 0, 8'h80);
    pulse_start(0);
    repeat (4) @(posedge clk);
    #1 pulse_start(0);
    repeat (34) @(posedge clk);
    #1 pulse_start(0);
    repeat (45) @(posedge clk);
    #1 expect_dones(0, 1);

    // aborted sweep: async reset mid-cycle at sweep cycle 35
    @(posedge clk);
    #1 arm(0, 0, 0, 8'h00);
    pulse_start(0);
    repeat (34) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    expect_dones(0, 0);

    // fresh sweep with f=~c
    sel[0] = 3'd2;
    @(posedge clk);
    #1 arm(0, 81, 0, 8'h55);
    pulse_start(0);
    repeat (85) @(posedge clk);
    #1 expect_dones(0, 1);

    // HOLD=1, start held high: back-to-back sweeps every 10 cycles
    @(posedge clk);
    #1 arm(1, 9, 10, 8'hFC);
    start[1] = 1'b1;
    repeat (45) @(posedge clk);
    #1 start[1] = 1'b0;
    repeat (15) @(posedge clk);
    #1 expect_dones(1, 5);

    // N=2, HOLD=3, f=stim[1]
    @(posedge clk);
    #1 arm(2, 13, 0, 8'h0C);
    pulse_start(2);
    repeat (16) @(posedge clk);
    #1 expect_dones(2, 1);

    repeat (2) @(posedge clk);
    #1 $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
